// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer for the 9-bit-instruction CPU: owns the PC and IR load,
// and turns the decoder's write enables into one commit strobe per instruction.
module pc_sequencer #(
   parameter int PC_WIDTH    = 10,
   parameter int MEM_LATENCY = 1,
   parameter int CYC_WIDTH   = 16
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic                 PC_Next_Sel,
   input  logic                 IsIndirect,
   input  logic [4:0]           BranchOffset,
   input  logic [7:0]           JumpTarget,
   input  logic                 RegWriteEnable,
   input  logic                 MemReadEnable,
   input  logic                 MemWriteEnable,
   input  logic                 Done_in,
   output logic [PC_WIDTH-1:0]  PC,
   output logic                 IR_Load,
   output logic                 RegWriteStrobe,
   output logic                 MemWriteStrobe,
   output logic                 MemReadStrobe,
   output logic                 Done,
   output logic [CYC_WIDTH-1:0] CycleCount
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      EXEC     = 3'd2,
      MEM_WAIT = 3'd3,
      HALT     = 3'd4
   } state_t;

   localparam bit                   HAS_WAIT  = (MEM_LATENCY > 0);
   localparam logic [2:0]           WAIT_INIT = HAS_WAIT ? 3'(MEM_LATENCY - 1) : 3'd0;
   localparam logic [PC_WIDTH-1:0]  PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CYC_WIDTH-1:0] CYC_ONE   = {{(CYC_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [2:0]           wait_q, wait_d;
   logic                 done_q, done_d;
   logic [CYC_WIDTH-1:0] cyc_q, cyc_d;
   logic                 commit;
   logic                 mem_access;
   logic [PC_WIDTH-1:0]  next_pc;

   assign mem_access = MemReadEnable | MemWriteEnable;

   // The commit cycle is the last cycle of an instruction: it carries the write strobes and the PC update.
   always_comb begin
      commit = 1'b0;
      case (state_q)
         EXEC:     commit = !Done_in && !(mem_access && HAS_WAIT);
         MEM_WAIT: commit = (wait_q == 3'd0);
         default:  commit = 1'b0;
      endcase
   end

   always_comb begin
      next_pc = pc_q + PC_ONE;
      if (PC_Next_Sel && IsIndirect) begin
         next_pc = PC_WIDTH'(JumpTarget);
      end else if (PC_Next_Sel) begin
         next_pc = pc_q + PC_WIDTH'(signed'(BranchOffset));
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      wait_d  = wait_q;
      done_d  = done_q;
      cyc_d   = cyc_q;
      if ((state_q inside {FETCH, EXEC, MEM_WAIT}) && !(&cyc_q)) begin
         cyc_d = cyc_q + CYC_ONE;
      end
      case (state_q)
         IDLE: begin
            pc_d   = '0;
            done_d = 1'b0;
            if (Start) state_d = FETCH;
         end
         FETCH: state_d = EXEC;
         EXEC: begin
            if (Done_in) begin
               state_d = HALT;
               done_d  = 1'b1;
            end else if (mem_access && HAS_WAIT) begin
               state_d = MEM_WAIT;
               wait_d  = WAIT_INIT;
            end else begin
               state_d = FETCH;
               pc_d    = next_pc;
            end
         end
         MEM_WAIT: begin
            if (wait_q == 3'd0) begin
               state_d = FETCH;
               pc_d    = next_pc;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         HALT: begin
            done_d = 1'b1;
            if (Start) begin
               state_d = IDLE;
               pc_d    = '0;
               done_d  = 1'b0;
               cyc_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pc_d    = '0;
            wait_d  = '0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         wait_q  <= '0;
         done_q  <= 1'b0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wait_q  <= wait_d;
         done_q  <= done_d;
         cyc_q   <= cyc_d;
      end
   end

   // A read is held for the whole access, from the EXEC cycle through the last wait cycle.
   assign MemReadStrobe  = MemReadEnable && (((state_q == EXEC) && !Done_in) || (state_q == MEM_WAIT));
   assign RegWriteStrobe = commit && RegWriteEnable;
   assign MemWriteStrobe = commit && MemWriteEnable;
   assign IR_Load        = (state_q == FETCH);
   assign PC             = pc_q;
   assign Done           = done_q;
   assign CycleCount     = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (MEM_LATENCY=3 so the wait-state paths are exercised).
module tb_pc_sequencer;

   localparam int PW = 10;
   localparam int CW = 16;

   logic          Clk = 1'b0;
   logic          Reset, Start, PC_Next_Sel, IsIndirect;
   logic [4:0]    BranchOffset;
   logic [7:0]    JumpTarget;
   logic          RegWriteEnable, MemReadEnable, MemWriteEnable, Done_in;
   logic [PW-1:0] PC;
   logic          IR_Load, RegWriteStrobe, MemWriteStrobe, MemReadStrobe, Done;
   logic [CW-1:0] CycleCount;

   always #5 Clk = ~Clk;

   pc_sequencer #(.PC_WIDTH(PW), .MEM_LATENCY(3), .CYC_WIDTH(CW)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .PC_Next_Sel(PC_Next_Sel),
      .IsIndirect(IsIndirect), .BranchOffset(BranchOffset), .JumpTarget(JumpTarget),
      .RegWriteEnable(RegWriteEnable), .MemReadEnable(MemReadEnable),
      .MemWriteEnable(MemWriteEnable), .Done_in(Done_in), .PC(PC), .IR_Load(IR_Load),
      .RegWriteStrobe(RegWriteStrobe), .MemWriteStrobe(MemWriteStrobe),
      .MemReadStrobe(MemReadStrobe), .Done(Done), .CycleCount(CycleCount)
   );

   // One record per clock cycle: inputs held for the cycle, outputs expected during it.
   typedef struct {
      string         name;
      logic          rst, start, sel, ind;
      logic [4:0]    off;
      logic [7:0]    jt;
      logic          rwe, mre, mwe, din;
      logic [PW-1:0] pc;
      logic          ir, rws, mws, mrs, done;
      logic [CW-1:0] cyc;
   } vec_t;

   int   checks = 0;
   int   fails  = 0;
   vec_t vecs[$];

   function automatic vec_t mkv(string n, logic rst, logic start, logic sel, logic ind,
                                logic [4:0] off, logic [7:0] jt, logic rwe, logic mre,
                                logic mwe, logic din, logic [PW-1:0] pc, logic ir,
                                logic rws, logic mws, logic mrs, logic done, logic [CW-1:0] cyc);
      vec_t v;
      v.name = n; v.rst = rst; v.start = start; v.sel = sel; v.ind = ind;
      v.off = off; v.jt = jt; v.rwe = rwe; v.mre = mre; v.mwe = mwe; v.din = din;
      v.pc = pc; v.ir = ir; v.rws = rws; v.mws = mws; v.mrs = mrs; v.done = done; v.cyc = cyc;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      @(posedge Clk);
      #1;
      Reset          = v.rst;
      Start          = v.start;
      PC_Next_Sel    = v.sel;
      IsIndirect     = v.ind;
      BranchOffset   = v.off;
      JumpTarget     = v.jt;
      RegWriteEnable = v.rwe;
      MemReadEnable  = v.mre;
      MemWriteEnable = v.mwe;
      Done_in        = v.din;
   endtask

   task automatic compareField(input string n, input string f, input logic [31:0] act,
                               input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s.%s: got %0d, expected %0d", n, f, act, exp);
      end
   endtask

   task automatic checkOutput(input vec_t v);
      @(negedge Clk);
      compareField(v.name, "PC",             32'(PC),             32'(v.pc));
      compareField(v.name, "IR_Load",        32'(IR_Load),        32'(v.ir));
      compareField(v.name, "RegWriteStrobe", 32'(RegWriteStrobe), 32'(v.rws));
      compareField(v.name, "MemWriteStrobe", 32'(MemWriteStrobe), 32'(v.mws));
      compareField(v.name, "MemReadStrobe",  32'(MemReadStrobe),  32'(v.mrs));
      compareField(v.name, "Done",           32'(Done),           32'(v.done));
      compareField(v.name, "CycleCount",     32'(CycleCount),     32'(v.cyc));
   endtask

   task automatic runVector(input vec_t v);
      applyStimulus(v);
      checkOutput(v);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      Reset = 1'b1; Start = 1'b0; PC_Next_Sel = 1'b0; IsIndirect = 1'b0;
      BranchOffset = '0; JumpTarget = '0; RegWriteEnable = 1'b0;
      MemReadEnable = 1'b0; MemWriteEnable = 1'b0; Done_in = 1'b0;
      repeat (2) @(posedge Clk);

      // Straight-line code, relative branches, JAL and both PC wrap paths.
      //                  name          rst st sel ind off       jt     rwe mre mwe din  pc   ir rws mws mrs dn cyc
      vecs.push_back(mkv("reset",       1, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv("idle_start",  0, 1, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv("fetch0",      0, 0, 0, 0, 5'd0,     8'h00, 1, 0, 0, 0,    0,   1, 0, 0, 0, 0, 0));
      vecs.push_back(mkv("exec0",       0, 0, 0, 0, 5'd0,     8'h00, 1, 0, 0, 0,    0,   0, 1, 0, 0, 0, 1));
      vecs.push_back(mkv("fetch1",      0, 0, 0, 0, 5'd0,     8'h00, 1, 0, 0, 0,    1,   1, 0, 0, 0, 0, 2));
      vecs.push_back(mkv("exec1",       0, 0, 0, 0, 5'd0,     8'h00, 1, 0, 0, 0,    1,   0, 1, 0, 0, 0, 3));
      vecs.push_back(mkv("fetch2",      0, 0, 0, 0, 5'd0,     8'h00, 1, 0, 0, 0,    2,   1, 0, 0, 0, 0, 4));
      vecs.push_back(mkv("exec2",       0, 0, 0, 0, 5'd0,     8'h00, 1, 0, 0, 0,    2,   0, 1, 0, 0, 0, 5));
      vecs.push_back(mkv("fetch3",      0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    3,   1, 0, 0, 0, 0, 6));
      vecs.push_back(mkv("br_p2",       0, 0, 1, 0, 5'd2,     8'h00, 0, 0, 0, 0,    3,   0, 0, 0, 0, 0, 7));
      vecs.push_back(mkv("fetch5a",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    5,   1, 0, 0, 0, 0, 8));
      vecs.push_back(mkv("br_m3",       0, 0, 1, 0, 5'b11101, 8'h00, 0, 0, 0, 0,    5,   0, 0, 0, 0, 0, 9));
      vecs.push_back(mkv("fetch2b",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    2,   1, 0, 0, 0, 0, 10));
      vecs.push_back(mkv("br_p3",       0, 0, 1, 0, 5'd3,     8'h00, 0, 0, 0, 0,    2,   0, 0, 0, 0, 0, 11));
      vecs.push_back(mkv("fetch5b",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    5,   1, 0, 0, 0, 0, 12));
      vecs.push_back(mkv("br_p15",      0, 0, 1, 0, 5'b01111, 8'h00, 0, 0, 0, 0,    5,   0, 0, 0, 0, 0, 13));
      vecs.push_back(mkv("fetch20",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    20,  1, 0, 0, 0, 0, 14));
      vecs.push_back(mkv("jmp7",        0, 0, 1, 1, 5'd0,     8'h07, 0, 0, 0, 0,    20,  0, 0, 0, 0, 0, 15));
      vecs.push_back(mkv("fetch7",      0, 0, 1, 1, 5'd0,     8'h40, 1, 0, 0, 0,    7,   1, 0, 0, 0, 0, 16));
      vecs.push_back(mkv("jal",         0, 0, 1, 1, 5'd0,     8'h40, 1, 0, 0, 0,    7,   0, 1, 0, 0, 0, 17));
      vecs.push_back(mkv("fetch64",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    64,  1, 0, 0, 0, 0, 18));
      vecs.push_back(mkv("jmp0",        0, 0, 1, 1, 5'd0,     8'h00, 0, 0, 0, 0,    64,  0, 0, 0, 0, 0, 19));
      vecs.push_back(mkv("fetch0b",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    0,   1, 0, 0, 0, 0, 20));
      vecs.push_back(mkv("br_m1",       0, 0, 1, 0, 5'b11111, 8'h00, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 21));
      vecs.push_back(mkv("fetch1023",   0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    1023,1, 0, 0, 0, 0, 22));
      vecs.push_back(mkv("br_wrap",     0, 0, 1, 0, 5'd1,     8'h00, 0, 0, 0, 0,    1023,0, 0, 0, 0, 0, 23));
      vecs.push_back(mkv("fetch0c",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    0,   1, 0, 0, 0, 0, 24));
      vecs.push_back(mkv("br_m1b",      0, 0, 1, 0, 5'b11111, 8'h00, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 25));
      vecs.push_back(mkv("fetch1023b",  0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    1023,1, 0, 0, 0, 0, 26));
      vecs.push_back(mkv("inc_wrap",    0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    1023,0, 0, 0, 0, 0, 27));
      vecs.push_back(mkv("fetch0d",     0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    0,   1, 0, 0, 0, 0, 28));
      vecs.push_back(mkv("br_p4",       0, 0, 1, 0, 5'd4,     8'h00, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 29));
      vecs.push_back(mkv("fetch4",      0, 0, 0, 0, 5'd0,     8'h00, 0, 0, 0, 0,    4,   1, 0, 0, 0, 0, 30));

      foreach (vecs[i]) runVector(vecs[i]);

      // Store at PC 4: write strobe only in the third wait cycle.
      runVector(mkv("st_exec",     0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 31));
      runVector(mkv("st_wait1",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 32));
      runVector(mkv("st_wait2",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 33));
      runVector(mkv("st_wait3",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 4, 0, 0, 1, 0, 0, 34));
      runVector(mkv("st_fetch5",   0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 5, 1, 0, 0, 0, 0, 35));

      // Load with register write: read held throughout, register write only at commit.
      runVector(mkv("ld_exec",     0, 0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 36));
      runVector(mkv("ld_wait1",    0, 0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 37));
      runVector(mkv("ld_wait2",    0, 0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 0, 5, 0, 0, 0, 1, 0, 38));
      runVector(mkv("ld_wait3",    0, 0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 0, 5, 0, 1, 0, 1, 0, 39));
      runVector(mkv("ld_fetch6",   0, 0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 0, 6, 1, 0, 0, 0, 0, 40));

      // Reset in the second wait cycle aborts the store.
      runVector(mkv("ab_exec",     0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 41));
      runVector(mkv("ab_wait1",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 42));
      runVector(mkv("ab_wait2_rst",1, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 6, 0, 0, 0, 0, 0, 43));
      runVector(mkv("ab_idle",     0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      runVector(mkv("ab_idle2",    0, 0, 1, 0, 5'd3, 8'h00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

      // Halt at PC 9, hold for ten cycles, then restart.
      runVector(mkv("h_start",     0, 1, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      runVector(mkv("h_fetch0",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      runVector(mkv("h_jmp9",      0, 0, 1, 1, 5'd0, 8'h09, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      runVector(mkv("h_fetch9",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 2));
      runVector(mkv("h_exec_halt", 0, 0, 1, 0, 5'd2, 8'h00, 1, 1, 1, 1, 9, 0, 0, 0, 0, 0, 3));
      for (int k = 0; k < 10; k++) begin
         runVector(mkv($sformatf("h_hold%0d", k), 0, 0, 1, 0, 5'd2, 8'h00, 1, 1, 1, 0,
                       9, 0, 0, 0, 0, 1, 4));
      end
      runVector(mkv("h_restart",   0, 1, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 9, 0, 0, 0, 0, 1, 4));
      runVector(mkv("h_idle",      0, 1, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Reset together with Start lands in IDLE; Start alone then fetches.
      runVector(mkv("rs_both",     1, 1, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      runVector(mkv("rs_idle",     0, 1, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      runVector(mkv("rs_fetch",    0, 0, 0, 0, 5'd0, 8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      runVector(mkv("rs_exec",     0, 0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
